// File: rtl/if_stage.sv
// if_stage: instruction fetch with FETCH/HOLD/DISCARD control, a one-entry skid buffer and the IF/ID register.
// Define IFID_NOP_FILL_EN to fill squashed IF/ID slots with the ARMv8 NOP instead of zero.
module if_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    output logic        ifid_valid,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [10:0] ifid_opcode
);
`ifdef IFID_NOP_FILL_EN
    localparam logic [31:0] FILL = 32'hD503201F;
`else
    localparam logic [31:0] FILL = 32'h0000_0000;
`endif
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_disc_addr;
    logic [63:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic [63:0] w_pc_inc;
    logic [63:0] w_target;
    assign w_pc_inc    = r_pc + 64'd4;
    assign w_target    = branch_target & ~64'd3;
    // DISCARD keeps presenting the abandoned request until memory answers it
    assign imem_req    = r_state != HOLD;
    assign imem_addr   = r_state == DISCARD ? r_disc_addr : r_pc;
    assign ifid_opcode = ifid_instr[31:21];
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= 64'd0;
            r_disc_addr  <= 64'd0;
            r_skid_pc    <= 64'd0;
            r_skid_instr <= 32'd0;
            ifid_valid   <= 1'b0;
            ifid_pc      <= 64'd0;
            ifid_instr   <= FILL;
        end else if (redirect) begin
            r_pc       <= w_target;
            ifid_valid <= 1'b0;
            ifid_instr <= FILL;
            r_state    <= (imem_valid || r_state == HOLD) ? FETCH : DISCARD;
            if (r_state == FETCH)
                r_disc_addr <= r_pc;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_valid && stall) begin
                        r_skid_pc    <= r_pc;
                        r_skid_instr <= imem_data;
                        r_pc         <= w_pc_inc;
                        r_state      <= HOLD;
                    end else if (imem_valid) begin
                        ifid_valid <= 1'b1;
                        ifid_pc    <= r_pc;
                        ifid_instr <= imem_data;
                        r_pc       <= w_pc_inc;
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_pc    <= r_skid_pc;
                        ifid_instr <= r_skid_instr;
                        r_state    <= FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_valid)
                        r_state <= FETCH;
                end
                default: r_state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus randomized stall/redirect/latency traffic checked by an in-order fetch-stream scoreboard.
module tb_if_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic        ifid_valid;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [10:0] ifid_opcode;
    int total = 0;
    int bad = 0;
    int lat = 0;
    int wcnt = 0;
    int consumed = 0;
    logic mon_en = 1'b0;
    logic [63:0] exp_q[$];
    logic prev_out = 1'b0;
    logic prev_rst = 1'b1;
    logic [63:0] prev_addr = 64'd0;
    logic [63:0] first_new;
`ifdef IFID_NOP_FILL_EN
    localparam logic [31:0] FILL = 32'hD503201F;
`else
    localparam logic [31:0] FILL = 32'h0000_0000;
`endif

    always #5 clock = ~clock;

    if_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_data(imem_data), .imem_valid(imem_valid), .ifid_valid(ifid_valid),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_opcode(ifid_opcode)
    );

    function automatic logic [31:0] word(input logic [63:0] a);
        return a == 64'd0 ? 32'h8B020020 : a == 64'd4 ? 32'hCB020020 : a[31:0] ^ a[63:32] ^ 32'h9E3779B9;
    endfunction

    // memory answers after lat wait cycles; lat=0 is zero-wait
    assign imem_valid = imem_req && (wcnt >= lat);
    assign imem_data  = imem_valid ? word(imem_addr) : 32'hDEADBEEF;
    always @(posedge clock) wcnt <= (reset || !imem_req || imem_valid) ? 0 : wcnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // an outstanding request must stay raised with a stable address
    always @(negedge clock) begin
        if (prev_out && !prev_rst) begin
            check("req_held", 64'(imem_req), 64'd1);
            check("addr_held", imem_addr, prev_addr);
        end
        prev_out  <= imem_req && !imem_valid;
        prev_addr <= imem_addr;
        prev_rst  <= reset;
    end

    always @(negedge clock) begin : sb_mon
        logic [63:0] e;
        logic [31:0] w;
        if (mon_en && ifid_valid && !stall && !redirect && !reset) begin
            consumed++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got pc %h with no expected entry", ifid_pc);
            end else begin
                e = exp_q.pop_front();
                w = word(e);
                check("sb_pc", ifid_pc, e);
                check("sb_instr", 64'(ifid_instr), 64'(w));
                check("sb_opcode", 64'(ifid_opcode), 64'(w[31:21]));
                exp_q.push_back(e + 64'd4);
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; branch_target = 64'd0; lat = 0;
        repeat (3) tick;
        check("rst_valid", 64'(ifid_valid), 64'd0);
        check("rst_pc", ifid_pc, 64'd0);
        check("rst_instr", 64'(ifid_instr), 64'(FILL));
        check("rst_req", 64'(imem_req), 64'd1);
        check("rst_addr", imem_addr, 64'd0);
        reset = 1'b0;
        tick;
        check("f0_valid", 64'(ifid_valid), 64'd1);
        check("f0_pc", ifid_pc, 64'd0);
        check("f0_op", 64'(ifid_opcode), 64'h458);
        tick;
        check("f1_valid", 64'(ifid_valid), 64'd1);
        check("f1_pc", ifid_pc, 64'd4);
        check("f1_op", 64'(ifid_opcode), 64'h658);
        check("f1_addr", imem_addr, 64'd8);
        stall = 1'b1;
        tick;
        check("hold_req", 64'(imem_req), 64'd0);
        check("hold_pc", ifid_pc, 64'd4);
        repeat (2) tick;
        check("hold2_req", 64'(imem_req), 64'd0);
        check("hold2_pc", ifid_pc, 64'd4);
        stall = 1'b0;
        tick;
        check("rel_pc", ifid_pc, 64'd8);
        check("rel_valid", 64'(ifid_valid), 64'd1);
        check("rel_addr", imem_addr, 64'hC);
        check("rel_req", 64'(imem_req), 64'd1);
        tick;
        check("next_pc", ifid_pc, 64'hC);
        stall = 1'b1; redirect = 1'b1; branch_target = 64'h103;
        tick;
        check("rd_addr", imem_addr, 64'h100);
        check("rd_valid", 64'(ifid_valid), 64'd0);
        check("rd_fill", 64'(ifid_instr), 64'(FILL));
        stall = 1'b0; redirect = 1'b0;
        tick;
        check("rd_pc", ifid_pc, 64'h100);
        check("rd_instr", 64'(ifid_instr), 64'(word(64'h100)));
        lat = 2; redirect = 1'b1; branch_target = 64'h40;
        tick;
        check("disc_req", 64'(imem_req), 64'd1);
        check("disc_addr", imem_addr, 64'h104);
        check("disc_valid", 64'(ifid_valid), 64'd0);
        redirect = 1'b0;
        first_new = 64'hFFFF;
        for (int i = 0; i < 20 && !ifid_valid; i++) begin
            tick;
            if (imem_addr != 64'h104 && first_new == 64'hFFFF) first_new = imem_addr;
        end
        check("disc_newreq", first_new, 64'h40);
        check("disc_arrive", 64'(ifid_valid), 64'd1);
        check("disc_pc", ifid_pc, 64'h40);
        check("disc_instr", 64'(ifid_instr), 64'(word(64'h40)));
        lat = 0; redirect = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick;
        check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        redirect = 1'b0;
        tick;
        check("wrap_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_next", imem_addr, 64'd0);
        tick;
        lat = 3; redirect = 1'b1; branch_target = 64'h200;
        tick;
        check("rdisc_addr", imem_addr, 64'd4);
        redirect = 1'b0; reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rdisc_req", 64'(imem_req), 64'd1);
        check("rdisc_fetch", imem_addr, 64'd0);
        check("rdisc_valid", 64'(ifid_valid), 64'd0);
        check("rdisc_pc", ifid_pc, 64'd0);
        lat = 0;
        tick;
        check("rdisc_f0", 64'(ifid_instr), 64'h8B020020);
        // randomized traffic; the scoreboard expects program order restarting at each redirect target
        redirect = 1'b1; branch_target = 64'h1000;
        exp_q.delete();
        exp_q.push_back(64'h1000);
        mon_en = 1'b1;
        repeat (2000) begin
            tick;
            stall = $urandom_range(0, 9) < 3;
            redirect = $urandom_range(0, 19) == 0;
            lat = $urandom_range(0, 2);
            if (redirect) begin
                branch_target = $urandom_range(0, 3) == 0 ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))) : {$urandom, $urandom};
                exp_q.delete();
                exp_q.push_back(branch_target & ~64'd3);
            end
        end
        stall = 1'b0; redirect = 1'b0;
        repeat (10) tick;
        mon_en = 1'b0;
        check("progress", 64'(consumed > 100), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 The block SHALL have port stall, input, 1 bit: hazard unit holds IF/ID contents and PC.
REQ-004 The block SHALL have port redirect, input, 1 bit: taken branch resolved downstream (B, BL, BR, CBZ/CBNZ taken).
REQ-005 The block SHALL have port branch_target, input, 64 bits: new PC on redirect.
REQ-006 The block SHALL have port imem_req, output, 1 bit: fetch request.
REQ-007 The block SHALL have port imem_addr, output, 64 bits: fetch address.
REQ-008 The block SHALL have port imem_data, input, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port imem_valid, input, 1 bit: imem_data valid this cycle.
REQ-010 The block SHALL have port ifid_valid, output, 1 bit: IF/ID slot holds a real instruction.
REQ-011 The block SHALL have port ifid_pc, output, 64 bits: PC of the IF/ID instruction.
REQ-012 The block SHALL have port ifid_instr, output, 32 bits: IF/ID instruction word.
REQ-013 The block SHALL have port ifid_opcode, output, 11 bits: ifid_instr[31:21], feeding the decode/control opcode input.

Function
REQ-014 The block SHALL implement states FETCH, HOLD and DISCARD.
REQ-015 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; in HOLD and DISCARD, imem_req SHALL be 0, except DISCARD SHALL keep imem_req=1 and imem_addr unchanged until imem_valid.
REQ-016 Memory protocol: once raised, imem_req and imem_addr SHALL stay stable until imem_valid; there is no withdrawal; zero-wait memory returns imem_valid in the same cycle.
REQ-017 FETCH with imem_valid=1, stall=0 and redirect=0: on the next edge, IF/ID SHALL load {pc, imem_data}, ifid_valid<=1, pc<=pc+4, and the state SHALL remain FETCH; throughput is 1 instruction per cycle and latency is 1 cycle.
REQ-018 FETCH with imem_valid=1, stall=1 and redirect=0: imem_data and pc SHALL be captured into a skid buffer, pc<=pc+4, state SHALL go to HOLD, and IF/ID SHALL be unchanged.
REQ-019 HOLD with stall=0: IF/ID SHALL load from the skid buffer with ifid_valid<=1, and state SHALL go to FETCH; HOLD with stall=1 SHALL cause no change.
REQ-020 FETCH with imem_valid=0 and stall=0: ifid_valid SHALL be set to 0 (bubble); with stall=1, IF/ID SHALL be held.
REQ-021 redirect=1 SHALL have priority over stall and imem_valid, and SHALL set pc<={branch_target[63:2],2'b00}, ifid_valid<=0, ifid_instr<=fill word (REQ-027), and drop the skid buffer.
REQ-022 On redirect in FETCH with imem_valid=0, the state SHALL go to DISCARD; with imem_valid=1 the response SHALL be dropped and the state SHALL stay in FETCH; from HOLD the state SHALL go to FETCH.
REQ-023 In DISCARD, the imem_valid response SHALL be dropped, then the state SHALL go to FETCH using the new pc; a redirect in DISCARD SHALL update pc and stay in DISCARD.
REQ-024 pc+4 SHALL wrap modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0).
REQ-025 ifid_opcode SHALL be purely combinational from ifid_instr.

Reset
REQ-026 When reset=1 at an edge: pc=0, state=FETCH, ifid_valid=0, ifid_pc=0, ifid_instr=fill word, skid buffer empty; reset SHALL override redirect and stall, and reset in DISCARD/HOLD SHALL abandon the outstanding request.

Configuration
REQ-027 With IFID_NOP_FILL_EN defined, the fill word SHALL be 0xD503201F (ARMv8 NOP); when undefined, the fill word SHALL be 0x00000000 (opcode 11'b0, decodes to no control case).

Verification
REQ-028 Reset, then zero-wait memory returning 0x8B020020 at 0 and 0xCB020020 at 4 -> ifid_pc 0 then 4, ifid_opcode 0x458 then 0x658, ifid_valid=1 each cycle.
REQ-029 stall=1 for 3 cycles while imem_valid=1 at pc=8 -> IF/ID held, HOLD entered, imem_req=0; after release IF/ID shows pc 8 and the next fetch is 0xC.
REQ-030 redirect=1 to 0x103 in the same cycle as stall=1 -> next pc 0x100, ifid_valid=0, ifid_instr = fill word (0xD503201F with macro, 0 without).
REQ-031 Memory with 2-cycle latency, redirect to 0x40 in the request's first wait cycle -> the stale response is discarded, the next request is to 0x40, and no stale instruction reaches IF/ID.
REQ-032 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr 0; reset asserted during DISCARD -> FETCH at pc 0, ifid_valid=0.
